// File: rtl/riscv_pkg.sv
// riscv_pkg: shared writeback types for the ALU/LSU regfile write-port arbiter.
package riscv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned STARVE_CNT_W = 4;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        NORMAL,
        FORCE_LSU
    } wb_arb_state_t;

    // x0 is hardwired to zero, so a completed request only writes for rd != 0
    function automatic logic wb_writes(input wb_req_t r);
        return r.valid && (r.rd != 5'd0);
    endfunction

endpackage

// File: rtl/wb_age_counter.sv
// wb_age_counter: counts consecutive cycles an LSU writeback is stalled and
// flags the cycle whose stall makes the count reach LIMIT.
module wb_age_counter
    import riscv_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_lose,
    input  logic i_clear,
    output logic o_hit
);

    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    assign o_hit = i_lose && (r_starve_cnt == STARVE_CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve_cnt <= '0;
        else if (i_clear)
            r_starve_cnt <= '0;
        else if (i_lose && r_starve_cnt != '1)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester (ALU, LSU) arbiter for the single regfile write port.
// Define WB_STARVE_GUARD_EN to add the LSU anti-starvation FSM; otherwise ALU has strict priority.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rf_wr_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data
);

    if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 2..15");
    end

    logic    w_force;
    logic    w_alu_hs;
    logic    w_lsu_hs;
    wb_req_t w_win;

    // Readies are mutually exclusive whenever both sides are valid, so one handshake at most
    assign alu_ready = !(lsu_valid && w_force);
    assign lsu_ready = !alu_valid || w_force;
    assign w_alu_hs  = alu_valid && alu_ready;
    assign w_lsu_hs  = lsu_valid && lsu_ready;
    assign w_win     = w_lsu_hs ? '{valid: 1'b1, rd: lsu_rd, data: lsu_data}
                                : '{valid: w_alu_hs, rd: alu_rd, data: alu_data};

`ifdef WB_STARVE_GUARD_EN
    wb_arb_state_t r_state;
    logic          w_hit;

    wb_age_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_age (
        .clk    (clk),
        .rst    (rst),
        .i_lose (lsu_valid && !lsu_ready),
        .i_clear(w_lsu_hs || !lsu_valid),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= NORMAL;
        else if (r_state == NORMAL && w_hit)
            r_state <= FORCE_LSU;
        else if (r_state == FORCE_LSU && (w_lsu_hs || !lsu_valid))
            r_state <= NORMAL;
    end

    assign w_force = (r_state == FORCE_LSU);
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en      <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else begin
            rf_wr_en <= wb_writes(w_win);
            if (w_win.valid) begin
                rf_rd         <= w_win.rd;
                rf_write_data <= w_win.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter; expectations follow
// the WB_STARVE_GUARD_EN setting of the build (STARVE_LIMIT = 4).
module tb_wb_arbiter;
    import riscv_pkg::*;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, lsu_valid;
    logic [4:0]      alu_rd, lsu_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ready, lsu_ready;
    logic            rf_wr_en;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .rf_wr_en     (rf_wr_en),
        .rf_rd        (rf_rd),
        .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", rf_wr_en); end
        n_cmp++;
        if (rf_rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", rf_rd); end
        n_cmp++;
        if (rf_write_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", rf_write_data); end
        n_cmp++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got alu=%b lsu=%b want 1/1", alu_ready, lsu_ready);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle_wr_en got %b want 0", rf_wr_en); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            n_bad++; $display("FAIL single_ready got alu=%b lsu=%b want 1/0", alu_ready, lsu_ready);
        end
        step();
        idle();
        n_cmp++;
        if (rf_wr_en !== 1'b1 || rf_rd !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL single_write got en=%b rd=%0d data=%h want 1/5/deadbeef", rf_wr_en, rf_rd, rf_write_data);
        end
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL single_after got en=%b want 0", rf_wr_en); end
    endtask

    task automatic test_contention(input logic [4:0] ard, input logic [4:0] lrd,
                                   input logic [31:0] ad, input logic [31:0] ld);
        alu_valid = 1'b1; alu_rd = ard; alu_data = ad;
        lsu_valid = 1'b1; lsu_rd = lrd; lsu_data = ld;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            n_bad++; $display("FAIL contend_ready got alu=%b lsu=%b want 1/0", alu_ready, lsu_ready);
        end
        step();
        alu_valid = 1'b0;
        n_cmp++;
        if (rf_wr_en !== 1'b1 || rf_rd !== ard || rf_write_data !== ad) begin
            n_bad++; $display("FAIL contend_first got en=%b rd=%0d data=%h want 1/%0d/%h", rf_wr_en, rf_rd, rf_write_data, ard, ad);
        end
        #1;
        n_cmp++;
        if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL contend_lsu_ready got %b want 1", lsu_ready); end
        step();
        idle();
        n_cmp++;
        if (rf_wr_en !== 1'b1 || rf_rd !== lrd || rf_write_data !== ld) begin
            n_bad++; $display("FAIL contend_second got en=%b rd=%0d data=%h want 1/%0d/%h", rf_wr_en, rf_rd, rf_write_data, lrd, ld);
        end
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL contend_after got en=%b want 0", rf_wr_en); end
    endtask

    // Both held valid for n cycles starting from a clean age count; with the guard the LSU wins every 5th cycle
    task automatic test_starve(input int n);
        logic exp_lsu;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11111111;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22222222;
        for (int k = 1; k <= n; k++) begin
            exp_lsu = GUARD && (k % 5 == 0);
            #1;
            n_cmp++;
            if (lsu_ready !== exp_lsu || alu_ready !== !exp_lsu) begin
                n_bad++; $display("FAIL starve_ready cyc=%0d got alu=%b lsu=%b want %b/%b", k, alu_ready, lsu_ready, !exp_lsu, exp_lsu);
            end
            step();
            n_cmp++;
            if (rf_wr_en !== 1'b1 || rf_rd !== (exp_lsu ? 5'd2 : 5'd1)) begin
                n_bad++; $display("FAIL starve_winner cyc=%0d got en=%b rd=%0d want 1/%0d", k, rf_wr_en, rf_rd, exp_lsu ? 2 : 1);
            end
        end
        idle();
        step();
    endtask

    task automatic test_x0();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        #1;
        n_cmp++;
        if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_lsu_ready got %b want 1", lsu_ready); end
        step();
        idle();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL x0_lsu_wr_en got %b want 0", rf_wr_en); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hCAFE;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_alu_ready got %b want 1", alu_ready); end
        step();
        idle();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL x0_alu_wr_en got %b want 0", rf_wr_en); end
        step();
    endtask

    task automatic test_reset_mid();
        logic exp_lsu;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5A5A5;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h5A5A5A5A;
        step();
        step();
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b1 || rf_rd !== 5'd9) begin
            n_bad++; $display("FAIL rmid_pre got en=%b rd=%0d want 1/9", rf_wr_en, rf_rd);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rf_wr_en !== 1'b0 || rf_rd !== 5'd0 || rf_write_data !== 32'h0) begin
            n_bad++; $display("FAIL rmid_async got en=%b rd=%0d data=%h want 0/0/0", rf_wr_en, rf_rd, rf_write_data);
        end
        step();
        rst = 1'b0;
        // Age count must restart from zero: LSU first wins on the 5th contended cycle after release
        for (int k = 1; k <= 5; k++) begin
            exp_lsu = GUARD && (k == 5);
            #1;
            n_cmp++;
            if (lsu_ready !== exp_lsu) begin
                n_bad++; $display("FAIL rmid_lsu_ready cyc=%0d got %b want %b", k, lsu_ready, exp_lsu);
            end
            step();
        end
        idle();
        step();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL rmid_idle_release got en=%b want 0", rf_wr_en); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_alu();
        test_contention(5'd3, 5'd4, 32'h00000333, 32'h00000444);
        test_contention(5'd7, 5'd7, 32'h77770001, 32'h77770002);
        test_starve(11);
        test_x0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
